// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, command encodings and default widths.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        READ  = 3'd4,
        END   = 3'd5
    } spi_state_e;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    localparam int WORD_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/spi_master_ctrl.sv
// SPI master: frames a latched command word MSB-first on MOSI and, for
// read-data commands, captures the reply from MISO after a turnaround gap.
// Every output is a flop loaded from the next-state decode.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_GAP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cmd_word,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              ss_n,
    output logic              MOSI,
    input  logic              MISO
);

    spi_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] rsr_q, rsr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;

    logic              is_rd_data;
    assign is_rd_data = (word_q[WORD_W-1 -: 2] == RD_DATA);

    // State, counter and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            rsr_q      <= '0;
            rd_data_q  <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            rsr_q      <= rsr_d;
            rd_data_q  <= rd_data_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next state: one down-counter times SHIFT, GAP and READ.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        rsr_d     = rsr_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d  = cmd_word;
                    state_d = CMD;
                end
            end
            CMD: begin
                state_d = SHIFT;
                cnt_d   = 4'(WORD_W - 1);
            end
            SHIFT: begin
                if (cnt_q == 4'd0) begin
                    state_d = is_rd_data ? GAP : END;
                    cnt_d   = 4'(READ_GAP - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = READ;
                    cnt_d   = 4'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READ: begin
                rsr_d = {rsr_q[DATA_W-2:0], MISO};
                if (cnt_q == 4'd0) begin
                    rd_data_d = rsr_d;
                    state_d   = END;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every pin comes straight off a flop.
    always_comb begin
        ss_n_d     = (state_d == IDLE) || (state_d == END);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == END);
        rd_valid_d = (state_d == END) && (word_d[WORD_W-1 -: 2] == RD_DATA);
        mosi_d     = 1'b0;
        case (state_d)
            CMD:     mosi_d = word_d[WORD_W-1];
            SHIFT:   mosi_d = word_d[cnt_d];
            default: mosi_d = 1'b0;
        endcase
    end

    assign ss_n     = ss_n_q;
    assign MOSI     = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: directed vector table, reset corner cases and
// randomized frames checked against a frame-level protocol model.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] cmd_word = '0;
    logic       MISO = 1'b0;
    logic       busy, done, rd_valid, ss_n, MOSI;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] rd_model = 8'h00;

    spi_master_ctrl #(.WORD_W(10), .DATA_W(8), .READ_GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_word(cmd_word),
        .busy(busy), .done(done), .rd_valid(rd_valid), .rd_data(rd_data),
        .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0]  cmd;
        logic [7:0]  reply;
        bit          hold;
        bit          churn;
        logic [10:0] exp_mosi;
        int          exp_len;
        bit          exp_rdv;
        logic [7:0]  exp_rd;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_idle_ssn"}, int'(ss_n), 1);
        chk({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    // Caller sits at a negedge; the accept happens on the following posedge.
    task automatic frame(input vec_t v, input string tag);
        logic [10:0] got_mosi;
        int ssn_bad, busy_bad, tail_bad, rdv_bad, done_c;
        int rdv_at, rd_at;
        bit seen;
        got_mosi = '0;
        ssn_bad = 0; busy_bad = 0; tail_bad = 0; rdv_bad = 0;
        done_c = 0; rdv_at = 0; rd_at = 0; seen = 0;
        start = 1'b1;
        cmd_word = v.cmd;
        @(posedge clk);
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (ss_n !== ((c <= v.exp_len) ? 1'b0 : 1'b1)) ssn_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (c <= 11) got_mosi = {got_mosi[9:0], MOSI};
            else if (MOSI !== 1'b0) tail_bad++;
            if (rd_valid && !done) rdv_bad++;
            if (done === 1'b1) begin
                seen   = 1;
                done_c = c;
                rdv_at = int'(rd_valid);
                rd_at  = int'(rd_data);
            end
            if (v.churn) cmd_word = 10'($urandom);
            if (v.hold) start = 1'b1;
            else if (v.churn) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
            if (c >= 12 + G && c <= 19 + G) MISO = v.reply[7 - (c - 12 - G)];
            else MISO = v.churn ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (!v.hold) start = 1'b0;
        MISO = 1'b0;
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_ssn_pattern"}, ssn_bad, 0);
        chk({tag, "_mosi"}, int'(got_mosi), int'(v.exp_mosi));
        chk({tag, "_mosi_tail"}, tail_bad, 0);
        chk({tag, "_busy"}, busy_bad, 0);
        chk({tag, "_done_cycle"}, done_c, v.exp_len + 1);
        chk({tag, "_rd_valid"}, rdv_at, int'(v.exp_rdv));
        chk({tag, "_rdv_stray"}, rdv_bad, 0);
        chk({tag, "_rd_data"}, rd_at, int'(v.exp_rd));
    endtask

    // Frame-level reference: what any command word must produce on the wire.
    function automatic vec_t model(input logic [9:0] cmd, input logic [7:0] reply,
                                   input bit hold, input bit churn);
        vec_t v;
        bit rd;
        rd = (cmd[9:8] == RD_DATA);
        v.cmd = cmd; v.reply = reply; v.hold = hold; v.churn = churn;
        v.exp_mosi = {cmd[9], cmd};
        v.exp_len  = 1 + 10 + (rd ? G + 8 : 0);
        v.exp_rdv  = rd;
        if (rd) rd_model = reply;
        v.exp_rd   = rd_model;
        return v;
    endfunction

    vec_t tbl[7];
    vec_t rv;

    initial begin
        tbl[0] = '{10'h0A5, 8'h00, 1'b0, 1'b0, 11'h0A5, 11, 1'b0, 8'h00};
        tbl[1] = '{10'h300, 8'hC3, 1'b1, 1'b0, 11'h700, 21, 1'b1, 8'hC3};
        tbl[2] = '{10'h1FF, 8'h00, 1'b1, 1'b0, 11'h1FF, 11, 1'b0, 8'hC3};
        tbl[3] = '{10'h25A, 8'h00, 1'b0, 1'b1, 11'h65A, 11, 1'b0, 8'hC3};
        tbl[4] = '{10'h3A5, 8'h5A, 1'b0, 1'b0, 11'h7A5, 21, 1'b1, 8'h5A};
        tbl[5] = '{10'h3FF, 8'hFF, 1'b0, 1'b1, 11'h7FF, 21, 1'b1, 8'hFF};
        tbl[6] = '{10'h166, 8'h00, 1'b0, 1'b1, 11'h166, 11, 1'b0, 8'hFF};

        // Reset held for three cycles with start low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ssn", int'(ss_n), 1);
            chk("rst_mosi", int'(MOSI), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_rd_data", int'(rd_data), 0);
        end
        rst_n = 1'b1;
        idle_chk("post_rst");

        // Directed table; entries 1-2 run back-to-back with start held high.
        for (int i = 0; i < 7; i++) begin
            frame(tbl[i], $sformatf("vec%0d", i));
            idle_chk($sformatf("vec%0d", i));
        end
        rd_model = 8'hFF;

        // Reset asserted at READ bit 4 of a read frame.
        start = 1'b1;
        cmd_word = 10'h3C3;
        @(posedge clk);
        for (int c = 1; c <= 12 + G + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            MISO = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrd_ssn", int'(ss_n), 1);
        chk("midrd_busy", int'(busy), 0);
        chk("midrd_rd_data", int'(rd_data), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrd_done", int'(done | rd_valid), 0);
        end
        MISO = 1'b0;
        rst_n = 1'b1;
        rd_model = 8'h00;
        idle_chk("midrd");
        rv = model(10'h0C3, 8'h00, 1'b0, 1'b0);
        frame(rv, "after_rst_wr");
        idle_chk("after_rst_wr");
        rv = model(10'h300, 8'h96, 1'b0, 1'b0);
        frame(rv, "after_rst_rd");
        idle_chk("after_rst_rd");

        // Randomized frames against the protocol model.
        for (int i = 0; i < 30; i++) begin
            rv = model(10'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
            frame(rv, $sformatf("rnd%0d", i));
            idle_chk($sformatf("rnd%0d", i));
        end
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
